store_align_buffer: RTL and testbench
=====================================

// Module: store_align_buffer
// PURPOSE
//  Store-side counterpart of the immediate/load extender. Takes a store from EX (register value, byte address, size).
//  Narrows and replicates the data onto the 32-bit data bus and generates byte strobes.
//  Queues the formatted stores in a small FIFO and drains them to the data-memory request port with a req/addr_ok handshake.
//  Sits between the EX/MEM boundary and the data SRAM/AXI bridge.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, 2..16
//  AW      3   pointer width (log2(DEPTH)+1); must match DEPTH
// PORTS
//  clk          in   1   single clock, rising edge
//  resetn       in   1   asynchronous, active-low reset
//  st_valid     in   1   store request from EX
//  st_ready     out  1   buffer can accept (= !full)
//  st_addr      in   32  byte address
//  st_data      in   32  register rt value (unaligned, LSB-justified)
//  st_size      in   2   0=byte(SB) 1=half(SH) 2=word(SW) 3=reserved
//  st_ades      out  1   address-error-on-store, combinational, same cycle
//  flush        in   1   exception/eret flush from WB
//  mem_req      out  1   write request valid (= !empty)
//  mem_addr     out  32  {addr[31:2],2'b00}
//  mem_wstrb    out  4   byte enables
//  mem_wdata    out  32  replicated data
//  mem_addr_ok  in   1   memory accepts head entry this cycle
//  buf_empty    out  1   no stores pending (for sync/cache-op drain)
//  ld_addr      in   32  load address from EX (hazard check)
//  ld_hazard    out  1   load must stall
// BEHAVIOUR
//  - Reset (async, resetn=0): rd/wr ptrs=0; mem_req=0, st_ready=1, buf_empty=1, ld_hazard=0; mem_addr/wstrb/wdata=0.
//  - Misalign: SH with addr[0]=1, SW with addr[1:0]!=0, or size=3 -> st_ades=st_valid&cond; store never enqueued, even if full.
//  - Push: st_valid & st_ready & !st_ades & !flush. Formatting done before write:
//    SB: wdata={4{d[7:0]}},  wstrb=4'b0001<<addr[1:0]
//    SH: wdata={2{d[15:0]}}, wstrb=addr[1]?4'b1100:4'b0011
//    SW: wdata=d,            wstrb=4'b1111
//  - Latency: pushed entry visible on mem_req the cycle after push (1 cycle); no bypass when empty.
//  - Pop: mem_req & mem_addr_ok; ptr advances at that edge; next entry presented the following cycle.
//  - Bus rule: once mem_req=1, mem_addr/wstrb/wdata hold stable until mem_addr_ok (head never changes under req).
//  - Full: st_ready=0; push and pop never coincide in a full buffer. Push+pop in the same cycle at partial occupancy: count unchanged.
//  - Pointers wrap modulo DEPTH; extra MSB distinguishes full (MSBs differ, rest equal) from empty.
//  - Flush: same-cycle push suppressed. If head is on the bus and not accepted this cycle, head retained and all younger entries dropped (wr_ptr=rd_ptr+1).
//    Otherwise (head accepted this cycle, or empty), buffer empties (wr_ptr=next rd_ptr).
//  - Reset mid-transaction: mem_req drops asynchronously; the in-flight store is lost (bus bridge is reset together).
// CONFIGURATION
//  STORE_FWD_HAZARD_EN defined: ld_hazard=1 iff any valid entry has mem_addr[31:2]==ld_addr[31:2]. Compare is over all DEPTH entries, combinational.
//  Not defined: ld_hazard=!buf_empty (conservative; any pending store stalls loads). Entry address compare logic is omitted.
// TESTING
//  1 SB addr=0x1003 d=0xAABBCCDD -> next cycle mem_req=1, addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD.
//  2 SH addr=0x2002 d=0x1234 then SH addr=0x2001 -> first: wstrb=1100, wdata=0x12341234. Second: st_ades=1, never seen on bus.
//  3 mem_addr_ok=0, push 4 SW -> st_ready=0 after 4th. Then hold mem_addr_ok=1 -> 4 pops in order over 4 cycles, buf_empty=1 after.
//  4 3 entries, mem_req held (addr_ok=0), flush=1 -> head stays stable, buffer count=1. addr_ok=1 -> pops, buf_empty=1.
//  5 Entry 0x3000 pending; ld_addr=0x3004 -> ld_hazard=0 with STORE_FWD_HAZARD_EN, 1 without; ld_addr=0x3002 -> 1 in both.
//  6 resetn=0 asserted while mem_req=1 -> mem_req=0 before next clk edge, st_ready=1 after release.

Source files
------------

// File: rtl/store_align_buffer.sv
// Store formatter + FIFO between EX/MEM and data memory request port.
// Optional macro: STORE_FWD_HAZARD_EN (exact per-entry load hazard).
// Ports: st_* store in/ades, flush, mem_* request out, buf_empty,
//        ld_addr/ld_hazard load-stall check.
module store_align_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_ades,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  output logic        buf_empty,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard
);

  localparam int IW = AW - 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [29:0]   addr_q [DEPTH];
  logic [3:0]    strb_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          mis;
  logic [3:0]    f_strb;
  logic [31:0]   f_data;
  logic          unused_ok;

  assign empty = wr_ptr == rd_ptr;
  assign full  = (wr_ptr[IW] != rd_ptr[IW]) &&
                 (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

  assign st_ready  = !full;
  assign mem_req   = !empty;
  assign buf_empty = empty;

  always_comb begin
    mis = 1'b0;
    unique case (1'b1)
      st_size == 2'd1: mis = st_addr[0];
      st_size == 2'd2: mis = st_addr[1:0] != 2'b00;
      st_size == 2'd3: mis = 1'b1;
      default:         mis = 1'b0;
    endcase
  end

  assign st_ades = st_valid & mis;
  assign push    = st_valid & st_ready & !mis & !flush;
  assign pop     = mem_req & mem_addr_ok;
  assign rd_next = rd_ptr + AW'(pop);

  always_comb begin
    f_data = st_data;
    f_strb = 4'b1111;
    unique case (1'b1)
      st_size == 2'd0: begin
        f_data = {4{st_data[7:0]}};
        f_strb = 4'b0001 << st_addr[1:0];
      end
      st_size == 2'd1: begin
        f_data = {2{st_data[15:0]}};
        f_strb = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        f_data = st_data;
        f_strb = 4'b1111;
      end
    endcase
  end

  // On flush, keep only a head that is still owed to the bus;
  // anything younger (or an accepted head) is discarded.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= rd_next;
      if (mem_req && !pop)
        wr_ptr <= rd_ptr + AW'(1);
      else
        wr_ptr <= rd_next;
    end else begin
      rd_ptr <= rd_next;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        strb_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (push) begin
      addr_q[wr_ptr[IW-1:0]] <= st_addr[31:2];
      strb_q[wr_ptr[IW-1:0]] <= f_strb;
      data_q[wr_ptr[IW-1:0]] <= f_data;
    end
  end

  assign mem_addr  = {addr_q[rd_ptr[IW-1:0]], 2'b00};
  assign mem_wstrb = strb_q[rd_ptr[IW-1:0]];
  assign mem_wdata = data_q[rd_ptr[IW-1:0]];

`ifdef STORE_FWD_HAZARD_EN
  logic [AW-1:0] count;
  logic [IW-1:0] off;
  logic          hit;

  assign count = wr_ptr - rd_ptr;

  // An entry is live when its distance from the head is below count.
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = IW'(i) - rd_ptr[IW-1:0];
      if (({1'b0, off} < count) &&
          (addr_q[i] == ld_addr[31:2]))
        hit = 1'b1;
    end
  end

  assign ld_hazard = hit;
  assign unused_ok = ^ld_addr[1:0];
`else
  assign ld_hazard = !empty;
  assign unused_ok = ^ld_addr;
`endif

endmodule

// File: tb/tb_store_align_buffer.sv
// Self-checking bench for store_align_buffer.
// Queue-based reference model, directed scenarios plus random traffic.
module tb_store_align_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        resetn;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        st_ades;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        buf_empty;
  logic [31:0] ld_addr;
  logic        ld_hazard;

  int   checks;
  int   errors;
  ent_t q[$];

  store_align_buffer #(.DEPTH(4), .AW(3)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data),
    .st_size(st_size), .st_ades(st_ades),
    .flush(flush), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .buf_empty(buf_empty), .ld_addr(ld_addr),
    .ld_hazard(ld_hazard)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic mis(logic [31:0] a, logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1) return (a % 2) != 0;
    if (s == 2'd2) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic ent_t fmt(logic [31:0] a, logic [31:0] d,
                               logic [1:0] s);
    ent_t e;
    e.a = (a / 4) * 4;
    if (s == 2'd0) begin
      e.d = 32'(d[7:0]) * 32'h0101_0101;
      e.s = 4'(1 << (a % 4));
    end else if (s == 2'd1) begin
      e.d = 32'(d[15:0]) * 32'h0001_0001;
      e.s = ((a % 4) >= 2) ? 4'd12 : 4'd3;
    end else begin
      e.d = d;
      e.s = 4'd15;
    end
    return e;
  endfunction

  function automatic logic hz(logic [31:0] la);
`ifdef STORE_FWD_HAZARD_EN
    foreach (q[i])
      if (q[i].a / 4 == la / 4) return 1'b1;
    return 1'b0;
`else
    return q.size() != 0;
`endif
  endfunction

  task automatic drive(logic v, logic [31:0] a, logic [31:0] d,
                       logic [1:0] s, logic ok, logic fl);
    st_valid    = v;
    st_addr     = a;
    st_data     = d;
    st_size     = s;
    mem_addr_ok = ok;
    flush       = fl;
  endtask

  // Advance one clock and update the reference queue.
  task automatic cycle();
    logic acc;
    logic pu;
    acc = (q.size() != 0) && mem_addr_ok;
    pu  = st_valid && (q.size() < DEPTH) &&
          !mis(st_addr, st_size) && !flush;
    @(posedge clk);
    if (flush) begin
      if (q.size() != 0 && !acc) begin
        while (q.size() > 1) void'(q.pop_back());
      end else begin
        q.delete();
      end
    end else begin
      if (acc) void'(q.pop_front());
      if (pu) q.push_back(fmt(st_addr, st_data, st_size));
    end
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    ld_addr = 32'h0;
    q.delete();
    #2;
    checks++;
    if ({mem_req, st_ready, buf_empty, ld_hazard} !== 4'b0110) begin
      errors++;
      $display("FAIL reset_flags got %b exp 0110",
               {mem_req, st_ready, buf_empty, ld_hazard});
    end
    checks++;
    if ({mem_addr, mem_wstrb, mem_wdata} !== 68'h0) begin
      errors++;
      $display("FAIL reset_bus got %h exp 0",
               {mem_addr, mem_wstrb, mem_wdata});
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_sb();
    drive(1, 32'h1003, 32'hAABB_CCDD, 0, 0, 0);
    #1;
    checks++;
    if (st_ades !== 1'b0) begin
      errors++; $display("FAIL sb_ades got %b exp 0", st_ades);
    end
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_wstrb, mem_wdata} !==
        {1'b1, 32'h1000, 4'b1000, 32'hDDDD_DDDD}) begin
      errors++;
      $display("FAIL sb_bus got %b %h %b %h exp 1 1000 1000 dddddddd",
               mem_req, mem_addr, mem_wstrb, mem_wdata);
    end
    mem_addr_ok = 1'b1;
    cycle();
    mem_addr_ok = 1'b0;
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++; $display("FAIL sb_drain got %b exp 1", buf_empty);
    end
  endtask

  task automatic test_sh();
    drive(1, 32'h2002, 32'h0000_1234, 1, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({mem_addr, mem_wstrb, mem_wdata} !==
        {32'h2000, 4'b1100, 32'h1234_1234}) begin
      errors++;
      $display("FAIL sh_bus got %h %b %h exp 2000 1100 12341234",
               mem_addr, mem_wstrb, mem_wdata);
    end
    drive(1, 32'h2001, 32'h0000_5678, 1, 1, 0);
    #1;
    checks++;
    if (st_ades !== 1'b1) begin
      errors++; $display("FAIL sh_ades got %b exp 1", st_ades);
    end
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (buf_empty !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL sh_noenq got empty=%b req=%b exp 1 0",
               buf_empty, mem_req);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] dv [4];
    for (int i = 0; i < 4; i++) begin
      dv[i] = $urandom;
      drive(1, 32'h4000 + 32'(4 * i), dv[i], 2, 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (st_ready !== 1'b0) begin
      errors++; $display("FAIL fill_ready got %b exp 0", st_ready);
    end
    drive(1, 32'h4003, 32'h1, 2, 0, 0);
    #1;
    checks++;
    if (st_ades !== 1'b1) begin
      errors++; $display("FAIL full_ades got %b exp 1", st_ades);
    end
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({mem_req, mem_addr, mem_wdata} !==
          {1'b1, 32'h4000 + 32'(4 * i), dv[i]}) begin
        errors++;
        $display("FAIL drain%0d got %b %h %h exp 1 %h %h", i,
                 mem_req, mem_addr, mem_wdata,
                 32'h4000 + 32'(4 * i), dv[i]);
      end
      cycle();
    end
    mem_addr_ok = 1'b0;
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++; $display("FAIL drain_empty got %b exp 1", buf_empty);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h5000 + 32'(4 * i), 32'h50 + 32'(i), 2, 0, 0);
      cycle();
    end
    drive(1, 32'h500C, 32'h99, 2, 0, 1);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h5000, 32'h50}) begin
      errors++;
      $display("FAIL flush_head got %b %h %h exp 1 5000 50",
               mem_req, mem_addr, mem_wdata);
    end
    mem_addr_ok = 1'b1;
    cycle();
    mem_addr_ok = 1'b0;
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++; $display("FAIL flush_count got %b exp 1", buf_empty);
    end
  endtask

  task automatic test_hazard();
    logic exp;
`ifdef STORE_FWD_HAZARD_EN
    exp = 1'b0;
`else
    exp = 1'b1;
`endif
    drive(1, 32'h3000, 32'h77, 2, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    ld_addr = 32'h3004;
    #1;
    checks++;
    if (ld_hazard !== exp) begin
      errors++; $display("FAIL hz_other got %b exp %b", ld_hazard, exp);
    end
    ld_addr = 32'h3002;
    #1;
    checks++;
    if (ld_hazard !== 1'b1) begin
      errors++; $display("FAIL hz_same got %b exp 1", ld_hazard);
    end
    mem_addr_ok = 1'b1;
    cycle();
    mem_addr_ok = 1'b0;
    #1;
    checks++;
    if (ld_hazard !== 1'b0) begin
      errors++; $display("FAIL hz_clear got %b exp 0", ld_hazard);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 32'h7000, 32'h1, 2, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_pre got %b exp 1", mem_req);
    end
    resetn = 1'b0;
    q.delete();
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL rst_async got %b exp 0", mem_req);
    end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++;
    if ({st_ready, buf_empty} !== 2'b11) begin
      errors++;
      $display("FAIL rst_after got %b exp 11", {st_ready, buf_empty});
    end
  endtask

  task automatic test_random();
    ent_t h;
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 6,
            32'h6000 + 32'($urandom_range(0, 31)),
            $urandom, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
      ld_addr = 32'h6000 + 32'($urandom_range(0, 31));
      #1;
      checks++;
      if (st_ades !== (st_valid && mis(st_addr, st_size))) begin
        errors++; $display("FAIL rnd_ades n=%0d got %b", n, st_ades);
      end
      checks++;
      if ({st_ready, mem_req, buf_empty} !==
          {q.size() < DEPTH, q.size() != 0, q.size() == 0}) begin
        errors++;
        $display("FAIL rnd_flags n=%0d got %b exp occupancy %0d",
                 n, {st_ready, mem_req, buf_empty}, q.size());
      end
      checks++;
      if (ld_hazard !== hz(ld_addr)) begin
        errors++;
        $display("FAIL rnd_hz n=%0d got %b exp %b", n, ld_hazard,
                 hz(ld_addr));
      end
      if (q.size() != 0) begin
        h = q[0];
        checks++;
        if ({mem_addr, mem_wstrb, mem_wdata} !== h) begin
          errors++;
          $display("FAIL rnd_head n=%0d got %h %b %h exp %h %b %h", n,
                   mem_addr, mem_wstrb, mem_wdata, h.a, h.s, h.d);
        end
      end
      cycle();
    end
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cycle();
    mem_addr_ok = 1'b0;
    checks++;
    if (buf_empty !== 1'b1) begin
      errors++; $display("FAIL rnd_final got %b exp 1", buf_empty);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sb();
    test_sh();
    test_fill_drain();
    test_flush();
    test_hazard();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
